freq_bcd_display: RTL and testbench
===================================

Name: freq_bcd_display

Overview:
- Downstream stage of the frequency/duty measurement block.
- Periodically snapshots the binary `freq[27:0]` (Hz) and `duty[6:0]` (%) values.
- Converts them to packed BCD with a sequential double-dabble engine, and produces leading-zero blanking masks for the display/segment driver.
- Includes a hold (freeze) input for the scope front panel.

Parameters:
- `REFRESH_CYCLES`, 10_000_000, clock cycles between display refreshes (10 Hz at 100 MHz). Must be >= 32.

Ports:
- `clk_100M`  in  1  system clock, 100 MHz
- `rst`  in  1  reset; synchronous and active-low (sampled on rising edge of `clk_100M`)
- `freq`  in  28  measured frequency in Hz, unsigned binary
- `duty`  in  7  measured duty cycle in %, unsigned binary
- `hold`  in  1  1 = freeze display; no new snapshots taken
- `freq_bcd`  out  36  9 BCD digits of frequency; digit i = `[4i+3:4i]`, digit 0 = units
- `duty_bcd`  out  12  3 BCD digits of duty, same packing
- `freq_blank`  out  9  bit i = 1 if digit i is a leading zero; bit 0 always 0
- `duty_blank`  out  3  same rule for duty digits
- `duty_ovf`  out  1  1 if the last snapshot had `duty` > 100
- `busy`  out  1  1 while a conversion is in progress
- `valid`  out  1  1-cycle pulse when outputs update

Behaviour:
- Reset (`rst` = 0 at a clock edge) sets:
  - `freq_bcd` = 0, `duty_bcd` = 0
  - `freq_blank` = 9'h1FE, `duty_blank` = 3'b110
  - `duty_ovf` = 0, `busy` = 0, `valid` = 0
  - refresh counter = 0, FSM = IDLE
- Reset mid-conversion aborts it: no `valid` pulse, and outputs take their reset values.
- Refresh counter:
  - Free-running 0..`REFRESH_CYCLES`-1, then wraps to 0.
  - `tick` = 1 in the cycle where count = `REFRESH_CYCLES`-1.
  - The counter is not affected by `hold`.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On `tick` & !`hold`, snapshot `freq` into the freq shift register and `min(duty,100)` into the duty shift register.
  - Latch `ovf_pending` = (`duty` > 100), clear the BCD accumulators, set bit counter = 0, go to SHIFT.
  - `busy` goes to 1 from the next cycle.
- SHIFT, one step per cycle:
  - Freq engine: each of the 9 accumulator digits >= 5 gets +3, then {acc, sreg} shifts left by 1.
  - Duty engine does the same on 3 digits, but only while bit counter < 7; afterwards it holds.
  - Bit counter increments each cycle. After the 28th shift (counter = 27 in that cycle), go to DONE.
- DONE (1 cycle):
  - Register the accumulators to `freq_bcd`/`duty_bcd`, compute the blank masks, set `duty_ovf` = `ovf_pending`.
  - `valid` = 1 for exactly this one cycle; `busy` = 0 from the next cycle; return to IDLE.
- Latency: snapshot at edge k, outputs and `valid` visible after edge k+29.
- Outputs hold their values between updates.
- Blank mask rule:
  - Digit i (i >= 1) is blanked iff it and all higher digits are 0.
  - Digit 0 is never blanked, so a value of 0 displays a single "0".
- `tick` while `busy`: ignored. This cannot occur when `REFRESH_CYCLES` >= 32.
- `hold`:
  - Sampled only in IDLE at `tick`.
  - Asserting `hold` during SHIFT does not abort; that conversion completes and pulses `valid`.
- Input changes after the snapshot do not affect the result in progress.
- Widths:
  - 28-bit max 268_435_455 fits in 9 digits; no frequency overflow is possible.
  - Duty is clamped to 100, so `duty_bcd` <= 12'h100.

Test Plan (`REFRESH_CYCLES` = 64):
1. Hold `rst` low for 3 cycles, then release.
   -> `freq_bcd` = 0, `duty_bcd` = 0, `freq_blank` = 9'h1FE, `duty_blank` = 3'b110, `valid` = 0, `busy` = 0.
   -> First `valid` occurs 29 cycles after the first `tick`.
2. `freq` = 1_000_000, `duty` = 50.
   -> `freq_bcd` = 36'h001000000, `freq_blank` = 9'h180, `duty_bcd` = 12'h050, `duty_blank` = 3'b100, `duty_ovf` = 0.
   -> `valid` is exactly 1 cycle wide, 29 cycles after the snapshot.
3. `freq` = 268_435_455, `duty` = 127.
   -> `freq_bcd` = 36'h268435455, `freq_blank` = 0, `duty_bcd` = 12'h100, `duty_blank` = 0, `duty_ovf` = 1.
   -> Next snapshot with `duty` = 7 -> `duty_bcd` = 12'h007, `duty_blank` = 3'b110, `duty_ovf` = 0.
4. `freq` = 0, `duty` = 0.
   -> All BCD outputs = 0, `freq_blank` = 9'h1FE, `duty_blank` = 3'b110.
   -> Also: change `freq` to 999 during SHIFT; the result must still reflect 0.
5. Set `freq` = 12345, then assert `hold` and change `freq` to 999 for 3 refresh periods.
   -> No `valid` pulses; `freq_bcd` stays 36'h000012345.
   -> Deassert `hold` -> next `tick` yields `freq_bcd` = 36'h000000999, `freq_blank` = 9'h1F8.
6. Pull `rst` low at shift cycle 10 of a conversion, for 1 cycle.
   -> Outputs return to reset values and no `valid` is issued for that conversion.
   -> The next `tick` after release converts normally.

Source files
------------

// File: rtl/freq_bcd_display.sv
// Snapshots binary frequency/duty on each refresh tick and converts them to packed BCD with a
// bit-serial double-dabble engine. Also produces leading-zero blanking masks for the display.
module freq_bcd_display #(
  parameter int unsigned REFRESH_CYCLES = 10_000_000
) (
  input  logic        clk_100M,
  input  logic        rst,
  input  logic [27:0] freq,
  input  logic [6:0]  duty,
  input  logic        hold,
  output logic [35:0] freq_bcd,
  output logic [11:0] duty_bcd,
  output logic [8:0]  freq_blank,
  output logic [2:0]  duty_blank,
  output logic        duty_ovf,
  output logic        busy,
  output logic        valid
);

  localparam int unsigned CntW = $clog2(REFRESH_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  // Add 3 to every BCD digit >= 5 ahead of the shift.
  function automatic logic [35:0] adj9(input logic [35:0] a);
    logic [35:0] r;
    r = a;
    for (int i = 0; i < 9; i++) begin
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [11:0] adj3(input logic [11:0] a);
    logic [11:0] r;
    r = a;
    for (int i = 0; i < 3; i++) begin
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Digit i blanks while it and every higher digit are zero; digit 0 always shows.
  function automatic logic [8:0] blank9(input logic [35:0] b);
    logic [8:0] r;
    logic       nz;
    r  = '0;
    nz = 1'b0;
    for (int i = 8; i >= 1; i--) begin
      nz   = nz | (b[4*i +: 4] != 4'd0);
      r[i] = ~nz;
    end
    return r;
  endfunction

  function automatic logic [2:0] blank3(input logic [11:0] b);
    logic [2:0] r;
    logic       nz;
    r  = '0;
    nz = 1'b0;
    for (int i = 2; i >= 1; i--) begin
      nz   = nz | (b[4*i +: 4] != 4'd0);
      r[i] = ~nz;
    end
    return r;
  endfunction

  logic [CntW-1:0] cnt_q;
  logic            tick;

  state_e      state_q, state_d;
  logic [27:0] freq_sr_q, freq_sr_d;
  logic [35:0] freq_acc_q, freq_acc_d;
  logic [6:0]  duty_sr_q, duty_sr_d;
  logic [11:0] duty_acc_q, duty_acc_d;
  logic [4:0]  bit_q, bit_d;
  logic        ovf_pend_q, ovf_pend_d;

  logic [35:0] freq_bcd_q, freq_bcd_d;
  logic [11:0] duty_bcd_q, duty_bcd_d;
  logic [8:0]  freq_blank_q, freq_blank_d;
  logic [2:0]  duty_blank_q, duty_blank_d;
  logic        duty_ovf_q, duty_ovf_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;

  logic [35:0] freq_adj;
  logic [11:0] duty_adj;

  assign tick     = (cnt_q == CntMax);
  assign freq_adj = adj9(freq_acc_q);
  assign duty_adj = adj3(duty_acc_q);

  // Free-running refresh counter; hold has no effect on it.
  always_ff @(posedge clk_100M) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + CntW'(1);
    end
  end

  // Snapshot, shift-and-add-3 steps, and output update.
  always_comb begin
    state_d      = state_q;
    freq_sr_d    = freq_sr_q;
    freq_acc_d   = freq_acc_q;
    duty_sr_d    = duty_sr_q;
    duty_acc_d   = duty_acc_q;
    bit_d        = bit_q;
    ovf_pend_d   = ovf_pend_q;
    freq_bcd_d   = freq_bcd_q;
    duty_bcd_d   = duty_bcd_q;
    freq_blank_d = freq_blank_q;
    duty_blank_d = duty_blank_q;
    duty_ovf_d   = duty_ovf_q;
    valid_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tick && !hold) begin
          freq_sr_d  = freq;
          duty_sr_d  = (duty > 7'd100) ? 7'd100 : duty;
          ovf_pend_d = (duty > 7'd100);
          freq_acc_d = '0;
          duty_acc_d = '0;
          bit_d      = '0;
          state_d    = StShift;
        end
      end
      StShift: begin
        {freq_acc_d, freq_sr_d} = {freq_adj[34:0], freq_sr_q, 1'b0};
        // Duty has only 7 significant bits; park it once they are consumed.
        if (bit_q < 5'd7) begin
          {duty_acc_d, duty_sr_d} = {duty_adj[10:0], duty_sr_q, 1'b0};
        end
        bit_d = bit_q + 5'd1;
        if (bit_q == 5'd27) state_d = StDone;
      end
      StDone: begin
        freq_bcd_d   = freq_acc_q;
        duty_bcd_d   = duty_acc_q;
        freq_blank_d = blank9(freq_acc_q);
        duty_blank_d = blank3(duty_acc_q);
        duty_ovf_d   = ovf_pend_q;
        valid_d      = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // State and output registers; reset aborts any conversion in flight.
  always_ff @(posedge clk_100M) begin
    if (!rst) begin
      state_q      <= StIdle;
      freq_sr_q    <= '0;
      freq_acc_q   <= '0;
      duty_sr_q    <= '0;
      duty_acc_q   <= '0;
      bit_q        <= '0;
      ovf_pend_q   <= 1'b0;
      freq_bcd_q   <= '0;
      duty_bcd_q   <= '0;
      freq_blank_q <= 9'h1FE;
      duty_blank_q <= 3'b110;
      duty_ovf_q   <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      freq_sr_q    <= freq_sr_d;
      freq_acc_q   <= freq_acc_d;
      duty_sr_q    <= duty_sr_d;
      duty_acc_q   <= duty_acc_d;
      bit_q        <= bit_d;
      ovf_pend_q   <= ovf_pend_d;
      freq_bcd_q   <= freq_bcd_d;
      duty_bcd_q   <= duty_bcd_d;
      freq_blank_q <= freq_blank_d;
      duty_blank_q <= duty_blank_d;
      duty_ovf_q   <= duty_ovf_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
    end
  end

  assign freq_bcd   = freq_bcd_q;
  assign duty_bcd   = duty_bcd_q;
  assign freq_blank = freq_blank_q;
  assign duty_blank = duty_blank_q;
  assign duty_ovf   = duty_ovf_q;
  assign busy       = busy_q;
  assign valid      = valid_q;

endmodule

// File: tb/tb_freq_bcd_display.sv
// Directed bench for freq_bcd_display: expected results are queued when inputs are set and
// compared when valid pulses; a side monitor checks snapshot-to-valid latency and pulse width.
module tb_freq_bcd_display;

  localparam int unsigned Refresh = 64;

  logic        clk_100M;
  logic        rst;
  logic [27:0] freq;
  logic [6:0]  duty;
  logic        hold;
  logic [35:0] freq_bcd;
  logic [11:0] duty_bcd;
  logic [8:0]  freq_blank;
  logic [2:0]  duty_blank;
  logic        duty_ovf;
  logic        busy;
  logic        valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [35:0] fb;
    logic [8:0]  fbl;
    logic [11:0] db;
    logic [2:0]  dbl;
    logic        ovf;
  } exp_t;

  exp_t sb[$];

  freq_bcd_display #(.REFRESH_CYCLES(Refresh)) dut (
    .clk_100M   (clk_100M),
    .rst        (rst),
    .freq       (freq),
    .duty       (duty),
    .hold       (hold),
    .freq_bcd   (freq_bcd),
    .duty_bcd   (duty_bcd),
    .freq_blank (freq_blank),
    .duty_blank (duty_blank),
    .duty_ovf   (duty_ovf),
    .busy       (busy),
    .valid      (valid)
  );

  initial begin
    clk_100M = 1'b0;
    forever #5 clk_100M = ~clk_100M;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by division, then leading-zero scan.
  function automatic exp_t model(input int unsigned f, input int unsigned d);
    exp_t        e;
    int unsigned v;
    logic        nz;
    v = f;
    for (int i = 0; i < 9; i++) begin
      e.fb[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    v = (d > 100) ? 100 : d;
    for (int i = 0; i < 3; i++) begin
      e.db[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    e.fbl = '0;
    nz    = 1'b0;
    for (int i = 8; i >= 1; i--) begin
      nz = nz | (e.fb[4*i +: 4] != 4'd0);
      e.fbl[i] = ~nz;
    end
    e.dbl = '0;
    nz    = 1'b0;
    for (int i = 2; i >= 1; i--) begin
      nz = nz | (e.db[4*i +: 4] != 4'd0);
      e.dbl[i] = ~nz;
    end
    e.ovf = (d > 100);
    return e;
  endfunction

  // Bench-side refresh counter and history of edges that should have taken a snapshot.
  logic [5:0]  mcnt = '0;
  logic [31:0] hist = '0;
  logic        valid_prev = 1'b0;

  always @(posedge clk_100M) begin
    if (!rst) mcnt <= '0;
    else      mcnt <= (mcnt == 6'(Refresh - 1)) ? '0 : mcnt + 6'd1;
    hist <= {hist[30:0], rst && (mcnt == 6'(Refresh - 1)) && !hold};
  end

  // Latency, busy and pulse-width checks sampled away from the active edge.
  always @(negedge clk_100M) begin
    if (hist[0]) chk("busy_after_snapshot", busy, 1);
    if (valid === 1'b1) begin
      chk("valid_latency_29", hist[29], 1);
      chk("busy_low_at_valid", busy, 0);
    end
    if (valid_prev) chk("valid_one_cycle", valid, 0);
    valid_prev = (valid === 1'b1);
  end

  task automatic wait_valid(input string tag);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk_100M);
      n++;
    end while (valid !== 1'b1 && n < 300);
    if (valid !== 1'b1) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout: got no valid expected valid within 300 cycles", tag);
    end else if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_unexpected: got valid expected none queued", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_freq_bcd"}, freq_bcd, e.fb);
      chk({tag, "_freq_blank"}, freq_blank, e.fbl);
      chk({tag, "_duty_bcd"}, duty_bcd, e.db);
      chk({tag, "_duty_blank"}, duty_blank, e.dbl);
      chk({tag, "_duty_ovf"}, duty_ovf, e.ovf);
    end
  endtask

  task automatic wait_busy(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk_100M);
      n++;
    end while (busy !== 1'b1 && n < 200);
    if (busy !== 1'b1) begin
      checks++;
      errors++;
      $error("FAIL %s_busy_timeout: got busy=%0b expected 1", tag, busy);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_freq_bcd"}, freq_bcd, 0);
    chk({tag, "_duty_bcd"}, duty_bcd, 0);
    chk({tag, "_freq_blank"}, freq_blank, 9'h1FE);
    chk({tag, "_duty_blank"}, duty_blank, 3'b110);
    chk({tag, "_duty_ovf"}, duty_ovf, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, valid, 0);
  endtask

  initial begin
    logic saw;
    rst  = 1'b0;
    hold = 1'b0;
    freq = 28'd1_000_000;
    duty = 7'd50;
    repeat (3) @(posedge clk_100M);
    @(negedge clk_100M);
    chk_reset_vals("reset");
    rst = 1'b1;

    // First tick converts 1 MHz / 50 %.
    sb.push_back(model(1_000_000, 50));
    wait_valid("mhz");

    // Full-scale frequency with duty over 100, then a small duty.
    freq = 28'd268_435_455;
    duty = 7'd127;
    sb.push_back(model(268_435_455, 127));
    wait_valid("max");
    duty = 7'd7;
    sb.push_back(model(268_435_455, 7));
    wait_valid("duty7");

    // Zero; input changes while shifting must not leak in.
    freq = 28'd0;
    duty = 7'd0;
    sb.push_back(model(0, 0));
    wait_busy("zero");
    repeat (5) @(negedge clk_100M);
    freq = 28'd999;
    wait_valid("zero");

    // Hold freezes the display across three refresh periods.
    freq = 28'd12345;
    sb.push_back(model(12345, 0));
    wait_valid("pre_hold");
    hold = 1'b1;
    freq = 28'd999;
    saw  = 1'b0;
    for (int i = 0; i < 3 * Refresh; i++) begin
      @(negedge clk_100M);
      if (valid === 1'b1) saw = 1'b1;
    end
    chk("hold_no_valid", saw, 0);
    chk("hold_freq_bcd", freq_bcd, 36'h000012345);
    hold = 1'b0;
    duty = 7'd127;
    sb.push_back(model(999, 127));
    wait_valid("post_hold");

    // Reset at shift cycle 10 aborts the conversion.
    freq = 28'd4321;
    duty = 7'd33;
    wait_busy("abort");
    repeat (10) @(negedge clk_100M);
    rst = 1'b0;
    @(negedge clk_100M);
    rst = 1'b1;
    chk_reset_vals("abort");
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_100M);
      if (valid === 1'b1) saw = 1'b1;
    end
    chk("abort_no_valid", saw, 0);
    sb.push_back(model(4321, 33));
    wait_valid("after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
